// File: rtl/err_inj_pkg.sv
// Shared encodings and constants for the error-injection controller.
package err_inj_pkg;

    localparam int         WORD_W_DEF = 7;
    localparam int         LFSR_W     = 7;
    localparam logic [6:0] LFSR_SEED  = 7'h01;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_DOUBLE = 2'd2,
        MODE_RANDOM = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/err_lfsr.sv
// 7-bit Fibonacci LFSR, polynomial x^7+x^6+1, advancing only when i_step is high.
module err_lfsr
    import err_inj_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= LFSR_SEED;
        end else if (i_step) begin
            r_state <= {r_state[5:0], r_state[6] ^ r_state[5]};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/err_inject_ctrl.sv
// Error-mask generator for a link test campaign; one mask per received word.
// Define ERR_INJ_LFSR_EN to build the LFSR used by RANDOM mode (otherwise mode 3 acts as NONE).
module err_inject_ctrl
    import err_inj_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [3:0]        period,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              word_done,
    output logic [WORD_W-1:0] mask,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  inj_count,
    output logic [1:0]        o_dbg_state
);

    localparam int                P_W     = $clog2(WORD_W + 1);
    localparam logic [P_W-1:0]    P_ONE   = P_W'(1);
    localparam logic [P_W-1:0]    P_MAX   = P_W'(WORD_W);
    localparam logic [WORD_W-1:0] MSB_ONE = WORD_W'(1) << (WORD_W - 1);

    state_t             r_state, w_next_state;
    mode_t              r_mode, w_sel_mode;
    logic [3:0]         r_period, r_phase;
    logic [CNT_W-1:0]   r_num_words, r_word_cnt, r_inj_count, w_inj_base;
    logic [P_W-1:0]     r_p, w_p_cur, w_p_nxt;
    logic [WORD_W-1:0]  r_mask, w_pat, w_next_mask;
    logic [3:0]         w_sel_per, w_per_eff, w_cur_phase, w_nxt_phase;
    logic               w_accept, w_wd_run, w_last, w_load, w_inj_word, w_pos_mode;

`ifdef ERR_INJ_LFSR_EN
    logic [LFSR_W-1:0]  w_lfsr;
    logic               w_lfsr_step;

    assign w_lfsr_step = w_load && w_inj_word && (w_sel_mode == MODE_RANDOM);

    err_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_step  (w_lfsr_step),
        .o_state (w_lfsr)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = (num_words == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (word_done && w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // On the accepting start, word 0 is computed from the live inputs rather than the latches.
    always_comb begin
        w_accept    = (r_state == ST_IDLE) && start;
        w_wd_run    = (r_state == ST_RUN) && word_done;
        w_last      = (r_word_cnt + CNT_W'(1)) == r_num_words;
        w_load      = (w_accept && (num_words != '0)) || (w_wd_run && !w_last);
        w_sel_mode  = w_accept ? mode_t'(mode) : r_mode;
        w_sel_per   = w_accept ? period : r_period;
        w_per_eff   = (w_sel_per == 4'd0) ? 4'd1 : w_sel_per;
        w_cur_phase = w_accept ? 4'd0 : r_phase;
        w_nxt_phase = (w_cur_phase == w_per_eff - 4'd1) ? 4'd0 : w_cur_phase + 4'd1;
        w_p_cur     = w_accept ? P_ONE : r_p;
        w_p_nxt     = (w_p_cur == P_MAX) ? P_ONE : w_p_cur + P_ONE;
        w_inj_word  = (w_cur_phase == 4'd0);
        w_inj_base  = w_accept ? '0 : r_inj_count;
        w_pat       = '0;
        w_pos_mode  = 1'b0;
        case (w_sel_mode)
            MODE_SINGLE: begin
                w_pat      = MSB_ONE >> (w_p_cur - P_ONE);
                w_pos_mode = 1'b1;
            end
            MODE_DOUBLE: begin
                w_pat      = (MSB_ONE >> (w_p_cur - P_ONE)) | (MSB_ONE >> (w_p_nxt - P_ONE));
                w_pos_mode = 1'b1;
            end
`ifdef ERR_INJ_LFSR_EN
            MODE_RANDOM: w_pat = WORD_W'(w_lfsr);
`endif
            default: w_pat = '0;
        endcase
        w_next_mask = w_inj_word ? w_pat : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode      <= MODE_NONE;
            r_period    <= 4'd0;
            r_num_words <= '0;
            r_word_cnt  <= '0;
            r_phase     <= 4'd0;
            r_p         <= P_ONE;
            r_mask      <= '0;
            r_inj_count <= '0;
        end else begin
            if (w_accept) begin
                r_mode      <= mode_t'(mode);
                r_period    <= period;
                r_num_words <= num_words;
                r_word_cnt  <= '0;
                r_phase     <= 4'd0;
                r_p         <= P_ONE;
                r_inj_count <= '0;
            end
            if (w_wd_run) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_mask  <= w_next_mask;
                r_phase <= w_nxt_phase;
                if (w_inj_word && w_pos_mode) begin
                    r_p <= w_p_nxt;
                end
                if ((|w_next_mask) && (w_inj_base != '1)) begin
                    r_inj_count <= w_inj_base + CNT_W'(1);
                end
            end else if (w_wd_run) begin
                r_mask <= '0;
            end
        end
    end

    assign mask        = r_mask;
    assign inj_count   = r_inj_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_err_inject_ctrl.sv
// Directed + randomized campaigns against a word-by-word reference model of the injection rules.
module tb_err_inject_ctrl;

`ifdef ERR_INJ_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [3:0] period;
    logic [7:0] num_words;
    logic       word_done;
    logic [6:0] mask;
    logic       busy;
    logic       done;
    logic [7:0] inj_count;
    logic [1:0] dbg_state;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [6:0] m_lfsr;
    bit         seen [128];

    always #5 clk = ~clk;

    err_inject_ctrl #(.WORD_W(7), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .period      (period),
        .num_words   (num_words),
        .word_done   (word_done),
        .mask        (mask),
        .busy        (busy),
        .done        (done),
        .inj_count   (inj_count),
        .o_dbg_state (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] pos_bit(input int p);
        logic [6:0] v;
        v = 7'h40;
        return v >> (p - 1);
    endfunction

    task automatic step_lfsr();
        m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    endtask

    // Word w is injected when w mod period == 0; the k-th injection uses bit position (k mod 7)+1.
    task automatic run_campaign(input logic [1:0] md, input logic [3:0] per,
                                input logic [7:0] nw, input bit dup_wd);
        int         pe;
        int         k;
        int         injc;
        int         p;
        logic [6:0] em;
        pe   = (per == 4'd0) ? 1 : int'(per);
        k    = 0;
        injc = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        mode      = md;
        period    = per;
        num_words = nw;
        start     = 1'b1;
        word_done = dup_wd;
        tick();
        start     = 1'b0;
        word_done = 1'b0;
        if (nw == 8'd0) begin
            chk("zero_busy", busy, 0);
            chk("zero_done", done, 1);
            chk("zero_mask", mask, 0);
            tick();
            chk("zero_done_end", done, 0);
            chk("zero_inj", inj_count, 0);
            return;
        end
        for (int w = 0; w < int'(nw); w++) begin
            if ((w % pe) == 0 && (md == 2'd1 || md == 2'd2 || (md == 2'd3 && LFSR_ON))) begin
                p = (k % 7) + 1;
                case (md)
                    2'd1:    em = pos_bit(p);
                    2'd2:    em = pos_bit(p) | pos_bit((p % 7) + 1);
                    default: begin
                        em = m_lfsr;
                        step_lfsr();
                    end
                endcase
                k++;
            end else begin
                em = 7'd0;
            end
            if (em != 7'd0) injc++;
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk($sformatf("mask_w%0d", w), mask, em);
            if (md == 2'd3 && em != 7'd0) begin
                chk("rand_distinct", seen[em], 0);
                seen[em] = 1'b1;
            end
            repeat ($urandom_range(0, 2)) begin
                start = 1'($urandom_range(0, 1));
                tick();
                start = 1'b0;
                chk("hold_mask", mask, em);
                chk("hold_busy", busy, 1);
            end
            word_done = 1'b1;
            tick();
            word_done = 1'b0;
        end
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        chk("end_mask", mask, 0);
        chk("end_inj", inj_count, injc);
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_inj", inj_count, injc);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        mode      = 2'd0;
        period    = 4'd0;
        num_words = 8'd0;
        word_done = 1'b0;
        m_lfsr    = 7'h01;
        tick();
        tick();
        rst = 1'b1;
        chk("rst_mask", mask, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_inj", inj_count, 0);
        chk("rst_state", dbg_state, 0);

        word_done = 1'b1;
        tick();
        word_done = 1'b0;
        chk("idle_wd_busy", busy, 0);
        chk("idle_wd_mask", mask, 0);

        run_campaign(2'd1, 4'd1, 8'd9, 1'b0);
        run_campaign(2'd2, 4'd3, 8'd7, 1'b1);
        run_campaign(2'd1, 4'd0, 8'd0, 1'b0);
        run_campaign(2'd0, 4'd2, 8'd5, 1'b0);

        word_done = 1'b1;
        tick();
        word_done = 1'b0;
        chk("post_wd_busy", busy, 0);
        chk("post_wd_inj", inj_count, 0);

        // Abort a campaign with reset after four words.
        mode      = 2'd1;
        period    = 4'd1;
        num_words = 8'd10;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) begin
            word_done = 1'b1;
            tick();
            word_done = 1'b0;
            tick();
        end
        chk("mid_mask", mask, pos_bit(5));
        chk("mid_inj", inj_count, 5);
        rst = 1'b0;
        tick();
        rst    = 1'b1;
        m_lfsr = 7'h01;
        chk("abort_mask", mask, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_inj", inj_count, 0);
        run_campaign(2'd1, 4'd1, 8'd3, 1'b0);

        run_campaign(2'd3, 4'd1, 8'd127, 1'b0);

        for (int c = 0; c < 8; c++) begin
            run_campaign(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                         8'($urandom_range(1, 24)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/err_inject_ctrl.md
ERR_INJECT_CTRL -- requirements
Module: err_inject_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 7, code-word width of the link mask.
REQ-002 SHALL have parameter CNT_W, default 8, width of word and injection counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a campaign.
REQ-006 SHALL have port mode  input  2  pattern: 0 NONE, 1 SINGLE, 2 DOUBLE, 3 RANDOM.
REQ-007 SHALL have port period  input  4  inject on every period-th word; 0 treated as 1.
REQ-008 SHALL have port num_words  input  CNT_W  campaign length in words.
REQ-009 SHALL have port word_done  input  1  one-cycle pulse from receiver when a word completes.
REQ-010 SHALL have port mask  output  WORD_W  error mask XORed into the current word, bit index 1..WORD_W.
REQ-011 SHALL have port busy  output  1  high in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse at campaign end.
REQ-013 SHALL have port inj_count  output  CNT_W  number of words given a nonzero mask this campaign.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 IDLE: on start, SHALL latch mode, period, num_words, clear word/phase/inj counters, set bit position p=1, go RUN; if num_words=0, go DONE instead.
REQ-016 start while in RUN or DONE SHALL be ignored.
REQ-017 word_done outside RUN SHALL be ignored.
REQ-018 mask SHALL be registered; valid from the cycle after RUN entry (word 0) and updated the cycle after each word_done (next word).
REQ-019 Word index w SHALL be an injection word when w mod period = 0 (word 0 always injected); non-injection words SHALL get mask 0.
REQ-020 SINGLE: injection mask SHALL have only bit p set; p advances 1..WORD_W per injection, wrapping WORD_W->1.
REQ-021 DOUBLE: injection mask SHALL set bits p and p+1, with p+1 wrapping WORD_W->1; p advances as SINGLE.
REQ-022 RANDOM: injection mask SHALL be the current LFSR state; LFSR steps once per injection word.
REQ-023 NONE: mask SHALL stay 0; inj_count stays 0.
REQ-024 inj_count SHALL increment once per injection word with nonzero mask, saturating at all-ones.
REQ-025 On the word_done making the word count equal num_words, SHALL go DONE with mask 0 next cycle.
REQ-026 DONE SHALL last exactly one cycle with done=1, then IDLE; inj_count holds until next start.
REQ-027 start and word_done in the same cycle in IDLE: start taken, word_done dropped.

Reset
REQ-028 rst low at a clock edge SHALL force IDLE, mask=0, busy=0, done=0, inj_count=0, p=1, LFSR=seed 7'h01, including mid-campaign.

Configuration
REQ-029 With ERR_INJ_LFSR_EN defined, RANDOM mode SHALL use a 7-bit maximal LFSR (x^7+x^6+1, seed 7'h01).
REQ-030 Without ERR_INJ_LFSR_EN, no LFSR logic SHALL be built and mode 3 SHALL behave as NONE.

Structure
REQ-031 Package err_inj_pkg SHALL hold the mode encoding, state encoding, WORD_W default and LFSR seed.
REQ-032 Sub-module err_lfsr (step enable, synchronous reset, 7-bit state out) SHALL be instantiated only under ERR_INJ_LFSR_EN.

Verification
REQ-033 mode=1, period=1, num_words=9: masks 1000000,0100000,...,0000001,1000000,0100000; inj_count=9; done one cycle after 9th word_done.
REQ-034 mode=2, period=3, num_words=7: word0 1100000, words1-2 0, word3 0110000, word6 0011000; inj_count=3.
REQ-035 num_words=0, start: no busy, done pulse within 2 cycles, mask 0.
REQ-036 rst low during RUN after 4 words: next cycle mask=0, busy=0; new start restarts at p=1, inj_count=0.
REQ-037 mode=3 with ERR_INJ_LFSR_EN, period=1, num_words=127: all 127 masks nonzero and distinct; without macro all masks 0.
